mips_multicycle_control: RTL

- Main control FSM for the multi-cycle MIPS datapath.
- Sequences fetch/decode/execute/memory/writeback over several clocks and drives every datapath select and write enable.
- Generates the 2-bit ALUOp consumed by the ALU control decoder.
- Stalls on a memory ready handshake, flags unsupported opcodes and counts retired instructions.

---
 rtl/mips_multicycle_control_pkg.sv | 57 +++++
 rtl/mips_multicycle_control_if.sv | 47 ++++
 rtl/mips_multicycle_control.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared constants and types for the multi-cycle MIPS control FSM.
//            Holds opcodes, the state enum, ALUOp codes and datapath select codes.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Opcodes from instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALUOp codes consumed by the ALU control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] ALUSRCB_RT    = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Control FSM states, 4-bit binary; codes 12..15 are unused
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  // True for every opcode the control unit knows how to sequence
  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_control_if
// Purpose  : Control/datapath bundle for the multi-cycle MIPS control FSM.
//            master = control unit, slave = datapath/memory side.
// Revision : 1.0 - initial release
// ============================================================================
interface mips_multicycle_control_if #(
  parameter int CNT_W = 32
);
  // Datapath to control
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             zero;
  // Control to datapath
  logic             pc_write;
  logic             pc_write_cond;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_src;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, mem_ready, zero,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, illegal_op, instr_count
  );

  modport slave (
    output opcode, mem_ready, zero,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, illegal_op, instr_count
  );

endinterface
`default_nettype wire

// File: rtl/mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_control
// Purpose  : Main control FSM of the multi-cycle MIPS datapath. Sequences
//            fetch/decode/execute/memory/writeback, stalls on mem_ready,
//            flags unsupported opcodes and counts retired instructions.
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_control
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  wire                                 clk,
  input  wire                                 rst_n,
  mips_multicycle_control_if.master           bus
);

  state_t             state_q;
  state_t             state_d;
  logic               illegal_q;
  logic               illegal_d;
  logic [CNT_W-1:0]   count_q;
  logic               retire;

  // State, illegal-opcode flag and retire counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (retire) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  // Next-state and datapath control decode from the current state
  always_comb begin
    state_d           = state_q;
    illegal_d         = 1'b0;
    retire            = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = ALUSRCB_RT;
    bus.alu_op        = ALUOP_ADD;
    bus.pc_src        = PCSRC_ALU;

    case (state_q)
      S_FETCH: begin
        // PC+4 is computed and written alongside the IR load
        bus.mem_read  = 1'b1;
        bus.alu_src_b = ALUSRCB_FOUR;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculatively form the branch target in ALUOut
        bus.alu_src_b = ALUSRCB_IMMSH;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
        illegal_d = !is_legal_op(bus.opcode);
      end
      S_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = ALUSRCB_IMM;
        state_d       = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        retire         = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEMWR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECUTE: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALUOP_FUNCT;
        state_d       = S_ALUWB;
      end
      S_ALUWB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        // The datapath gates the PC with zero
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = ALUOP_SUB;
        bus.pc_src        = PCSRC_ALUOUT;
        bus.pc_write_cond = 1'b1;
        retire            = 1'b1;
        state_d           = S_FETCH;
      end
      S_ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = ALUSRCB_IMM;
        state_d       = S_ADDIWB;
      end
      S_ADDIWB: begin
        bus.reg_write = 1'b1;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_src   = PCSRC_JUMP;
        bus.pc_write = 1'b1;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Registered outputs onto the bus
  always_comb begin
    bus.illegal_op  = illegal_q;
    bus.instr_count = count_q;
  end

endmodule
`default_nettype wire
